divu_sequencer: RTL and testbench

Control and result stage directly upstream and downstream of the unsigned iterative divider. It accepts a DIVU request, latches the operands, and clears the divider before each operation. It then drives the divider's 6-bit Signal input for exactly 32 DIVU cycles plus one OUT cycle, and captures the divider's 64-bit dataOut into the HI/LO registers. HI/LO are also readable and writable through MFHI/MFLO/MTHI/MTLO function codes.

---
 rtl/divu_sequencer_pkg.sv | 26 ++
 rtl/divu_sequencer_hilo_regs.sv | 45 ++++
 rtl/divu_sequencer.sv | 123 ++++++++++++
 tb/tb_divu_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/divu_sequencer_pkg.sv
// Shared constants and FSM state type for the DIVU sequencer and its HI/LO register file.
package divu_sequencer_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;

    // Divider command codes driven on Signal
    localparam logic [5:0] SIG_NONE = 6'd0;
    localparam logic [5:0] DIVU     = 6'd27;
    localparam logic [5:0] OUT      = 6'd63;

    // HI/LO access function codes
    localparam logic [5:0] MFHI = 6'd16;
    localparam logic [5:0] MTHI = 6'd17;
    localparam logic [5:0] MFLO = 6'd18;
    localparam logic [5:0] MTLO = 6'd19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_FETCH,
        S_LATCH
    } state_t;

endpackage

// File: rtl/divu_sequencer_hilo_regs.sv
// HI/LO storage: divide capture has priority over MTHI/MTLO writes; rd_data is a pure mux.
module divu_sequencer_hilo_regs
    import divu_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cap_en,
    input  logic [WIDTH-1:0] i_cap_hi,
    input  logic [WIDTH-1:0] i_cap_lo,
    input  logic             i_mt_en,
    input  logic [5:0]       i_funct,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_cap_en) begin
            r_hi <= i_cap_hi;
            r_lo <= i_cap_lo;
        end else if (i_mt_en) begin
            if (i_funct == MTHI) r_hi <= i_wr_data;
            if (i_funct == MTLO) r_lo <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data = '0;
        if (i_funct == MFHI) o_rd_data = r_hi;
        if (i_funct == MFLO) o_rd_data = r_lo;
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/divu_sequencer.sv
// Sequences the iterative unsigned divider: clear, ITER DIVU steps, one OUT step, capture into HI/LO.
module divu_sequencer
    import divu_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = DIV_ITER
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [2*WIDTH-1:0] div_result,
    output logic               div_reset,
    output logic [5:0]         Signal,
    output logic [WIDTH-1:0]   dataA,
    output logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   rd_data
);

    localparam int             CW       = $clog2(ITER);
    localparam logic [CW-1:0]  CNT_LAST = CW'(ITER - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dataA;
    logic [WIDTH-1:0] r_dataB;
    logic             r_dbz;

    logic             w_accept;
    logic             w_dz;
    logic             w_cap_en;
    logic [WIDTH-1:0] w_cap_hi;
    logic [WIDTH-1:0] w_cap_lo;
    logic             w_mt_en;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_dz     = w_accept && (opB == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dataA <= '0;
            r_dataB <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Zero divisor bypasses the divider entirely
                        if (opB == '0) begin
                            r_dbz   <= 1'b1;
                            r_state <= S_LATCH;
                        end else begin
                            r_dataA <= opA;
                            r_dataB <= opB;
                            r_dbz   <= 1'b0;
                            r_state <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    r_cnt   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_state <= S_FETCH;
                end
                S_FETCH: r_state <= S_LATCH;
                S_LATCH: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Signal = SIG_NONE;
        case (r_state)
            S_RUN:   Signal = DIVU;
            S_FETCH: Signal = OUT;
            default: Signal = SIG_NONE;
        endcase
    end

    assign div_reset   = reset || (r_state == S_CLR);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_LATCH);
    assign div_by_zero = r_dbz;
    assign dataA       = r_dataA;
    assign dataB       = r_dataB;

    // A divide by zero captures at the accepting edge: remainder = dividend, quotient = all ones
    assign w_cap_en = (r_state == S_FETCH) || w_dz;
    assign w_cap_hi = (r_state == S_FETCH) ? div_result[2*WIDTH-1:WIDTH] : opA;
    assign w_cap_lo = (r_state == S_FETCH) ? div_result[WIDTH-1:0]       : '1;
    assign w_mt_en  = (r_state == S_IDLE) && !start;

    divu_sequencer_hilo_regs #(
        .WIDTH(WIDTH)
    ) u_hilo (
        .clk      (clk),
        .rst      (reset),
        .i_cap_en (w_cap_en),
        .i_cap_hi (w_cap_hi),
        .i_cap_lo (w_cap_lo),
        .i_mt_en  (w_mt_en),
        .i_funct  (funct),
        .i_wr_data(wr_data),
        .o_hi     (hi),
        .o_lo     (lo),
        .o_rd_data(rd_data)
    );

endmodule

// File: tb/tb_divu_sequencer.sv
// Directed bench for divu_sequencer with a restoring-division model standing in for the divider.
module tb_divu_sequencer;
    import divu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] opA = '0, opB = '0, wr_data = '0;
    logic [5:0]  funct = '0;
    logic [63:0] div_result;
    logic        div_reset, busy, done, div_by_zero;
    logic [5:0]  Signal;
    logic [31:0] dataA, dataB, hi, lo, rd_data;

    int total = 0;
    int bad   = 0;

    divu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .opA(opA), .opB(opB),
        .funct(funct), .wr_data(wr_data), .div_result(div_result),
        .div_reset(div_reset), .Signal(Signal), .dataA(dataA), .dataB(dataB),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Divider model: cleared by div_reset, one restoring step per DIVU edge
    logic [31:0] m_rem, m_quo;
    logic        m_ld;
    always @(posedge clk) begin : divider_model
        logic [32:0] r;
        logic [31:0] q;
        if (div_reset) begin
            m_rem <= '0;
            m_quo <= '0;
            m_ld  <= 1'b0;
        end else if (Signal == 6'd27) begin
            q = m_ld ? m_quo : dataA;
            r = {m_rem, q[31]};
            q = {q[30:0], 1'b0};
            if (r >= {1'b0, dataB}) begin
                r    = r - {1'b0, dataB};
                q[0] = 1'b1;
            end
            m_rem <= r[31:0];
            m_quo <= q;
            m_ld  <= 1'b1;
        end
    end
    assign div_result = {m_rem, m_quo};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and follow the operation back to IDLE; n counts edges after the accepting edge
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic hold,
                           input logic [5:0] fn, input logic [31:0] wd,
                           output int done_at, output int ndone, output int nrun,
                           output int nout, output logic [31:0] mid_rd);
        start = 1'b1; opA = a; opB = b;
        tick();
        if (!hold) start = 1'b0;
        funct = fn; wr_data = wd;
        done_at = -1; ndone = 0; nrun = 0; nout = 0; mid_rd = '0;
        for (int n = 0; n < 100; n++) begin
            if (Signal == 6'd27) nrun++;
            if (Signal == 6'd63) nout++;
            if (n == 10) mid_rd = rd_data;
            if (done) begin done_at = n; ndone++; end
            if (!busy) break;
            tick();
        end
        start = 1'b0; funct = '0;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0h exp=0", done); end
        total++; if (div_reset !== 1'b1) begin bad++; $display("FAIL rst_divreset got=%0h exp=1", div_reset); end
        total++; if (Signal !== 6'd0) begin bad++; $display("FAIL rst_signal got=%0d exp=0", Signal); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL rst_hilo got=%0h exp=0", {hi, lo}); end
        total++; if ({dataA, dataB} !== 64'd0) begin bad++; $display("FAIL rst_data got=%0h exp=0", {dataA, dataB}); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_dbz got=%0h exp=0", div_by_zero); end
        reset = 1'b0;
        tick();
        total++; if (div_reset !== 1'b0) begin bad++; $display("FAIL idle_divreset got=%0h exp=0", div_reset); end
    endtask

    task automatic test_basic();
        int da, nd, nr, no;
        logic [31:0] mr;
        for (int k = 0; k < 2; k++) begin
            run_div(32'd100, 32'd7, 1'b0, 6'd0, 32'd0, da, nd, nr, no, mr);
            total++; if (nr !== 32) begin bad++; $display("FAIL basic_runcycles got=%0d exp=32", nr); end
            total++; if (no !== 1) begin bad++; $display("FAIL basic_outcycles got=%0d exp=1", no); end
            total++; if (da !== 34) begin bad++; $display("FAIL basic_done_at got=%0d exp=34", da); end
            total++; if (nd !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", nd); end
            total++; if (hi !== 32'd2) begin bad++; $display("FAIL basic_hi got=%0d exp=2", hi); end
            total++; if (lo !== 32'd14) begin bad++; $display("FAIL basic_lo got=%0d exp=14", lo); end
        end
        total++; if (dataA !== 32'd100 || dataB !== 32'd7) begin bad++; $display("FAIL basic_latched got=%0d/%0d exp=100/7", dataA, dataB); end
    endtask

    task automatic test_extreme();
        int da, nd, nr, no;
        logic [31:0] mr;
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 6'd0, 32'd0, da, nd, nr, no, mr);
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ext_max_lo got=%0h exp=ffffffff", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL ext_max_hi got=%0h exp=0", hi); end
        // MFLO mid-divide must still show the previous quotient
        run_div(32'd5, 32'd9, 1'b0, MFLO, 32'd0, da, nd, nr, no, mr);
        total++; if (mr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ext_mflo_old got=%0h exp=ffffffff", mr); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL ext_small_lo got=%0h exp=0", lo); end
        total++; if (hi !== 32'd5) begin bad++; $display("FAIL ext_small_hi got=%0h exp=5", hi); end
    endtask

    task automatic test_div_zero();
        int da, nd, nr, no;
        logic [31:0] mr;
        run_div(32'd42, 32'd0, 1'b0, 6'd0, 32'd0, da, nd, nr, no, mr);
        total++; if (da !== 0) begin bad++; $display("FAIL dz_done_at got=%0d exp=0", da); end
        total++; if (nr !== 0) begin bad++; $display("FAIL dz_runcycles got=%0d exp=0", nr); end
        total++; if (hi !== 32'd42) begin bad++; $display("FAIL dz_hi got=%0d exp=42", hi); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_lo got=%0h exp=ffffffff", lo); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%0h exp=1", div_by_zero); end
        run_div(32'd20, 32'd3, 1'b0, 6'd0, 32'd0, da, nd, nr, no, mr);
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_clear got=%0h exp=0", div_by_zero); end
        total++; if (lo !== 32'd6 || hi !== 32'd2) begin bad++; $display("FAIL dz_next got=%0d/%0d exp=6/2", lo, hi); end
    endtask

    task automatic test_arbitration();
        int da, nd, nr, no;
        logic [31:0] mr;
        run_div(32'd50, 32'd6, 1'b1, 6'd0, 32'd0, da, nd, nr, no, mr);
        total++; if (nd !== 1 || nr !== 32) begin bad++; $display("FAIL arb_hold_ops got=%0d/%0d exp=1/32", nd, nr); end
        total++; if (lo !== 32'd8 || hi !== 32'd2) begin bad++; $display("FAIL arb_hold_res got=%0d/%0d exp=8/2", lo, hi); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arb_hold_idle got=%0h exp=0", busy); end
        run_div(32'd77, 32'd10, 1'b0, MTHI, 32'h1234, da, nd, nr, no, mr);
        total++; if (hi !== 32'd7 || lo !== 32'd7) begin bad++; $display("FAIL arb_mthi_run got=%0h/%0h exp=7/7", hi, lo); end
        funct = MTLO; wr_data = 32'hABCD;
        tick();
        funct = MFLO;
        #1;
        total++; if (lo !== 32'hABCD) begin bad++; $display("FAIL arb_mtlo got=%0h exp=abcd", lo); end
        total++; if (rd_data !== 32'hABCD) begin bad++; $display("FAIL arb_mflo got=%0h exp=abcd", rd_data); end
        funct = MFHI;
        #1;
        total++; if (rd_data !== 32'd7) begin bad++; $display("FAIL arb_mfhi got=%0h exp=7", rd_data); end
        // start in the same cycle as MTLO: the write is dropped
        funct = MTLO; wr_data = 32'h5555; start = 1'b1; opA = 32'd7; opB = 32'd0;
        tick();
        start = 1'b0; funct = '0;
        total++; if (done !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin bad++; $display("FAIL arb_start_wins got=%0h/%0h/%0h exp=1/ffffffff/7", done, lo, hi); end
        tick();
    endtask

    task automatic test_reset_mid();
        int da, nd, nr, no, seen;
        logic [31:0] mr;
        start = 1'b1; opA = 32'd100; opB = 32'd7;
        tick();
        start = 1'b0;
        repeat (15) tick();
        total++; if (Signal !== 6'd27) begin bad++; $display("FAIL rmid_in_run got=%0d exp=27", Signal); end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || div_reset !== 1'b1) begin bad++; $display("FAIL rmid_async got=%0h/%0h exp=0/1", busy, div_reset); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL rmid_hilo got=%0h exp=0", {hi, lo}); end
        tick(); tick();
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (done || busy) seen++;
            tick();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", seen); end
        run_div(32'd81, 32'd9, 1'b0, 6'd0, 32'd0, da, nd, nr, no, mr);
        total++; if (da !== 34) begin bad++; $display("FAIL rmid_next_done got=%0d exp=34", da); end
        total++; if (lo !== 32'd9 || hi !== 32'd0) begin bad++; $display("FAIL rmid_next_res got=%0d/%0d exp=9/0", lo, hi); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extreme();
        test_div_zero();
        test_arbitration();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
